// File: rtl/coin_payout_pkg.sv
// Shared types and default sizing for the coin-return hopper sequencer.
// Imported by the controller, its timer and its interface.
package coin_payout_pkg;

    localparam int AMT_W_DEF       = 4;
    localparam int PULSE_CYC_DEF   = 4;
    localparam int TIMEOUT_CYC_DEF = 16;
    localparam int MAX_RETRY_DEF   = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRIVE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } state_e;

    // Counter width that can hold 0 .. n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/coin_payout_if.sv
// Request, hopper and status signals between the vend FSM and the
// payout controller; the controller takes the slave side.
interface coin_payout_if #(
    parameter int AMT_W = 4
);
    logic             req_valid;
    logic [AMT_W-1:0] req_amt;
    logic             req_ready;
    logic             coin_seen;
    logic             hop_empty;
    logic             fault_clr;
    logic             hop_drive;
    logic             busy;
    logic             done;
    logic             fault;
    logic [AMT_W-1:0] paid_cnt;

    modport master (
        output req_valid, req_amt, coin_seen, hop_empty, fault_clr,
        input  req_ready, hop_drive, busy, done, fault, paid_cnt
    );

    modport slave (
        input  req_valid, req_amt, coin_seen, hop_empty, fault_clr,
        output req_ready, hop_drive, busy, done, fault, paid_cnt
    );
endinterface

// File: rtl/coin_payout_timer.sv
// Up-counter with synchronous clear and a terminal-count flag that is
// high in the TERM-th counted cycle (count value TERM-1).
module payout_timer
    import coin_payout_pkg::*;
#(
    parameter int TERM = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int W = cnt_w(TERM);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: clear wins over enable.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == W'(TERM - 1));
endmodule

// File: rtl/coin_payout_ctrl.sv
// Coin-return hopper sequencer: pulses the motor one coin at a time,
// confirms each coin, retries on a miss, faults on jam or empty hopper.
module coin_payout_ctrl
    import coin_payout_pkg::*;
#(
    parameter int AMT_W       = AMT_W_DEF,
    parameter int PULSE_CYC   = PULSE_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int MAX_RETRY   = MAX_RETRY_DEF
) (
    input  logic         clk,
    input  logic         rst,
    coin_payout_if.slave bus
);
    localparam int RW = cnt_w(MAX_RETRY);

    state_e           state_q, state_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [AMT_W-1:0] paid_q, paid_d;
    logic [RW-1:0]    retry_q, retry_d;

    logic hop_drive_q, hop_drive_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic fault_q, fault_d;
    logic ready_q, ready_d;

    logic accept;
    logic coin_ev;
    logic pulse_tc, pulse_stay;
    logic wait_tc, wait_stay;

    assign accept  = bus.req_valid && (state_q == IDLE);
    assign coin_ev = bus.coin_seen
                     && ((state_q == DRIVE) || (state_q == WAIT));

    // Next state and counters; a coin is always accounted before an
    // empty hopper is allowed to fault the refund.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        paid_d  = paid_q;
        retry_d = retry_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    rem_d   = bus.req_amt;
                    paid_d  = '0;
                    retry_d = '0;
                    if (bus.req_amt == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = DRIVE;
                    end
                end
            end
            DRIVE, WAIT: begin
                if (coin_ev) begin
                    rem_d   = rem_q - AMT_W'(1);
                    paid_d  = paid_q + AMT_W'(1);
                    retry_d = '0;
                    if (rem_q == AMT_W'(1)) begin
                        state_d = DONE;
                    end else if (bus.hop_empty) begin
                        state_d = FAULT;
                    end else begin
                        state_d = DRIVE;
                    end
                end else if (bus.hop_empty) begin
                    state_d = FAULT;
                end else if ((state_q == DRIVE) && pulse_tc) begin
                    state_d = WAIT;
                end else if ((state_q == WAIT) && wait_tc) begin
                    if (retry_q == RW'(MAX_RETRY - 1)) begin
                        state_d = FAULT;
                    end else begin
                        retry_d = retry_q + RW'(1);
                        state_d = DRIVE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            FAULT: begin
                if (bus.fault_clr) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Timers run only while the same pulse or wait window continues;
    // any exit or fresh pulse restarts them from zero.
    assign pulse_stay = (state_q == DRIVE) && (state_d == DRIVE)
                        && !coin_ev;
    assign wait_stay  = (state_q == WAIT) && (state_d == WAIT);

    payout_timer #(
        .TERM (PULSE_CYC)
    ) u_pulse (
        .clk (clk),
        .rst (rst),
        .clr (!pulse_stay),
        .en  (pulse_stay),
        .tc  (pulse_tc)
    );

    payout_timer #(
        .TERM (TIMEOUT_CYC)
    ) u_wait (
        .clk (clk),
        .rst (rst),
        .clr (!wait_stay),
        .en  (wait_stay),
        .tc  (wait_tc)
    );

    // Outputs decoded from the next state so they leave a register.
    always_comb begin
        hop_drive_d = (state_d == DRIVE);
        busy_d      = (state_d == DRIVE) || (state_d == WAIT);
        done_d      = (state_d == DONE);
        fault_d     = (state_d == FAULT);
        ready_d     = (state_d == IDLE);
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            paid_q      <= '0;
            retry_q     <= '0;
            hop_drive_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            paid_q      <= paid_d;
            retry_q     <= retry_d;
            hop_drive_q <= hop_drive_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            ready_q     <= ready_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.hop_drive = hop_drive_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.fault     = fault_q;
    assign bus.paid_cnt  = paid_q;
endmodule

// File: tb/tb_coin_payout_ctrl.sv
// Directed bench for coin_payout_ctrl; completed refunds are checked
// against a queue of expected paid counts popped on each done pulse.
module tb_coin_payout_ctrl;
    import coin_payout_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   sbq[$];

    coin_payout_if #(.AMT_W(4)) bus ();

    coin_payout_ctrl #(
        .AMT_W       (4),
        .PULSE_CYC   (4),
        .TIMEOUT_CYC (16),
        .MAX_RETRY   (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Length of the current hop_drive pulse; leaves us in the first
    // cycle after the pulse.
    task automatic pulse_len(output int n);
        n = 0;
        while (bus.hop_drive === 1'b1 && n < 50) begin
            n++;
            step();
        end
    endtask

    // Cycles with hop_drive low and no fault, bounded.
    task automatic low_len(output int n);
        n = 0;
        while (bus.hop_drive === 1'b0 && bus.fault === 1'b0
               && n < 100) begin
            n++;
            step();
        end
    endtask

    task automatic send(input int amt);
        bus.req_valid = 1'b1;
        bus.req_amt   = 4'(amt);
        step();
        bus.req_valid = 1'b0;
        bus.req_amt   = '0;
    endtask

    task automatic coin(input logic empty);
        bus.coin_seen = 1'b1;
        bus.hop_empty = empty;
        step();
        bus.coin_seen = 1'b0;
        bus.hop_empty = 1'b0;
    endtask

    // Scoreboard consumer: every done pulse must match a queued refund.
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                chk("sb_paid", int'(bus.paid_cnt), sbq.pop_front());
            end
        end
    end

    initial begin
        int n;
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_amt   = '0;
        bus.coin_seen = 1'b0;
        bus.hop_empty = 1'b0;
        bus.fault_clr = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_ready", int'(bus.req_ready), 1);
        chk("rst_drive", int'(bus.hop_drive), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_fault", int'(bus.fault), 0);
        chk("rst_paid", int'(bus.paid_cnt), 0);

        // Three coins, each seen two cycles into WAIT.
        sbq.push_back(3);
        send(3);
        chk("t1_busy", int'(bus.busy), 1);
        for (int c = 0; c < 3; c++) begin
            pulse_len(n);
            chk("t1_pulse", n, 4);
            chk("t1_wait_busy", int'(bus.busy), 1);
            step();
            coin(1'b0);
            if (c < 2) begin
                chk("t1_paid_mid", int'(bus.paid_cnt), c + 1);
            end
        end
        chk("t1_done", int'(bus.done), 1);
        chk("t1_ready_j1", int'(bus.req_ready), 0);
        step();
        chk("t1_ready", int'(bus.req_ready), 1);
        chk("t1_done_off", int'(bus.done), 0);
        chk("t1_paid", int'(bus.paid_cnt), 3);

        // Zero-amount request.
        sbq.push_back(0);
        send(0);
        chk("t2_done", int'(bus.done), 1);
        chk("t2_drive", int'(bus.hop_drive), 0);
        step();
        chk("t2_ready", int'(bus.req_ready), 1);
        chk("t2_paid", int'(bus.paid_cnt), 0);

        // No coin ever arrives: two pulses, two timeouts, fault.
        send(1);
        pulse_len(n);
        chk("t3_pulse1", n, 4);
        low_len(n);
        chk("t3_wait1", n, 16);
        pulse_len(n);
        chk("t3_pulse2", n, 4);
        low_len(n);
        chk("t3_wait2", n, 16);
        chk("t3_fault", int'(bus.fault), 1);
        chk("t3_paid", int'(bus.paid_cnt), 0);
        chk("t3_ready", int'(bus.req_ready), 0);
        chk("t3_busy", int'(bus.busy), 0);
        bus.req_valid = 1'b1;
        bus.req_amt   = 4'd2;
        step();
        bus.req_valid = 1'b0;
        chk("t3_req_ignored", int'(bus.fault), 1);
        bus.fault_clr = 1'b1;
        step();
        bus.fault_clr = 1'b0;
        chk("t3_clr_fault", int'(bus.fault), 0);
        chk("t3_clr_ready", int'(bus.req_ready), 1);

        // One coin then the hopper runs empty.
        send(3);
        pulse_len(n);
        step();
        coin(1'b0);
        chk("t4_paid1", int'(bus.paid_cnt), 1);
        chk("t4_redrive", int'(bus.hop_drive), 1);
        bus.hop_empty = 1'b1;
        step();
        bus.hop_empty = 1'b0;
        chk("t4_fault", int'(bus.fault), 1);
        chk("t4_drive", int'(bus.hop_drive), 0);
        chk("t4_paid", int'(bus.paid_cnt), 1);
        bus.fault_clr = 1'b1;
        step();
        bus.fault_clr = 1'b0;
        chk("t4_ready", int'(bus.req_ready), 1);
        chk("t4_paid_hold", int'(bus.paid_cnt), 1);

        // Last coin arrives together with hopper empty.
        sbq.push_back(2);
        send(2);
        pulse_len(n);
        step();
        coin(1'b0);
        pulse_len(n);
        chk("t5_pulse2", n, 4);
        step();
        coin(1'b1);
        chk("t5_done", int'(bus.done), 1);
        chk("t5_fault", int'(bus.fault), 0);
        chk("t5_paid", int'(bus.paid_cnt), 2);
        step();
        chk("t5_ready", int'(bus.req_ready), 1);

        // Reset in the middle of a drive pulse.
        send(3);
        step();
        chk("t6_pre_drive", int'(bus.hop_drive), 1);
        rst = 1'b1;
        step();
        chk("t6_drive", int'(bus.hop_drive), 0);
        chk("t6_busy", int'(bus.busy), 0);
        chk("t6_ready", int'(bus.req_ready), 1);
        chk("t6_paid", int'(bus.paid_cnt), 0);
        rst = 1'b0;
        repeat (3) step();
        chk("t6_idle_drive", int'(bus.hop_drive), 0);
        chk("sb_empty", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
